// File: rtl/ser_univ.sv
// ser_univ: universal shift register with serial/parallel I/O and a frame counter
module ser_univ #(
    parameter int WIDTH = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    localparam int CW = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       mode,
    input  logic             sin,
    input  logic [WIDTH-1:0] pin,
    output logic [WIDTH-1:0] pout,
    output logic             sout,
    output logic [CW-1:0]    count,
    output logic             frame_done
);
    localparam logic [CW-1:0] FULL = CW'(WIDTH);
    logic             shift;
    logic [WIDTH-1:0] pout_n;
    logic             sout_n;
    logic [CW-1:0]    count_n;
    always_comb begin
        shift   = mode[0] ^ mode[1];
        pout_n  = mode == 2'b11 ? pin :
                  mode == 2'b01 ? {pout[WIDTH-2:0], sin} :
                  mode == 2'b10 ? {sin, pout[WIDTH-1:1]} : pout;
        sout_n  = mode == 2'b01 ? pout[WIDTH-1] : mode == 2'b10 ? pout[0] : sout;
        // a full counter wraps straight to 1 so back-to-back frames have no gap
        count_n = mode == 2'b11 ? '0 :
                  shift ? (count == FULL ? CW'(1) : count + 1'b1) : count;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            pout       <= RESET_VAL;
            sout       <= 1'b0;
            count      <= '0;
            frame_done <= 1'b0;
        end else begin
            pout       <= pout_n;
            sout       <= sout_n;
            count      <= count_n;
            frame_done <= shift && count_n == FULL;
        end
    end
endmodule
